// File: rtl/button_repeat_pkg.sv
// ============================================================================
// Module : button_repeat_pkg
// Brief  : Shared state encodings and default 50 MHz cycle counts for the
//          board push-button input blocks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package button_repeat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
    localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 5000000;   // 100 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_repeat_sync_debounce.sv
// ============================================================================
// Module : sync_debounce
// Brief  : Two-flop synchronizer and debounce counter for one active-low
//          button; produces the debounced level and press/release pulses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_debounce
    import button_repeat_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic rise,
    output logic fall
);

    localparam int              CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   c_cnt_max = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_meta_n;
    logic          r_sync_n;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;

    logic w_sync;
    logic w_diff;
    logic w_done;

    assign w_sync = ~r_sync_n;
    assign w_diff = (w_sync != r_level);
    assign w_done = w_diff && (r_cnt == c_cnt_max);

    // Early versions of the pulses, valid the cycle before level toggles
    assign rise = w_done && !r_level;
    assign fall = w_done && r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta_n  <= 1'b1;
            r_sync_n  <= 1'b1;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_meta_n  <= btn_n;
            r_sync_n  <= r_meta_n;
            if (!w_diff || w_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_done) begin
                r_level <= ~r_level;
            end
            r_press   <= rise;
            r_release <= fall;
        end
    end

    assign level         = r_level;
    assign press         = r_press;
    assign release_pulse = r_release;

endmodule

`default_nettype wire

// File: rtl/button_repeat.sv
// ============================================================================
// Module : button_repeat
// Brief  : Debounced push-button with press/release pulses, long-press
//          auto-repeat and a one-cycle step strobe for the counter enable.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module button_repeat
    import button_repeat_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic rpt,
    output logic step,
    output logic long_hold
);

    localparam int            CW           = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [CW-1:0] c_delay_max  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] c_period_max = CW'(REPEAT_PERIOD - 1);

    logic w_rise;
    logic w_fall;

    btn_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_rpt;
    logic          r_step;
    logic          r_long;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_n         (btn_n),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .rise          (w_rise),
        .fall          (w_fall)
    );

    // The FSM moves on the same edge as press/release so the hold count
    // is referenced to the press pulse itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rpt   <= 1'b0;
            r_step  <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_rpt  <= 1'b0;
            r_step <= w_rise;
            if (w_fall) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_long  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_long <= 1'b0;
                        if (w_rise) begin
                            r_state <= ST_HELD;
                            r_cnt   <= '0;
                        end
                    end
                    ST_HELD: begin
                        if (r_cnt == c_delay_max) begin
                            if (repeat_en) begin
                                r_rpt   <= 1'b1;
                                r_step  <= 1'b1;
                                r_cnt   <= '0;
                                r_state <= ST_REPEAT;
                                r_long  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (!repeat_en) begin
                            // Park saturated so re-enabling repeats at once
                            r_state <= ST_HELD;
                            r_cnt   <= c_delay_max;
                            r_long  <= 1'b0;
                        end else if (r_cnt == c_period_max) begin
                            r_rpt  <= 1'b1;
                            r_step <= 1'b1;
                            r_cnt  <= '0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_long  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rpt       = r_rpt;
    assign step      = r_step;
    assign long_hold = r_long;

endmodule

`default_nettype wire

// File: tb/tb_button_repeat.sv
// ============================================================================
// Module : tb_button_repeat
// Brief  : Directed self-checking bench for button_repeat (small parameters).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_button_repeat;

    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_n = 1'b1;
    logic repeat_en = 1'b0;
    logic level, press, release_pulse, rpt, step, long_hold;

    int errors = 0;
    int checks = 0;
    int n_rpt, n_step, n_press, first_press;
    logic bad;

    button_repeat #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (DLY),
        .REPEAT_PERIOD   (PER)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_n         (btn_n),
        .repeat_en     (repeat_en),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .rpt           (rpt),
        .step          (step),
        .long_hold     (long_hold)
    );

    always #5 clk = ~clk;

    // Output vector order: level, press, release, rpt, step, long_hold
    typedef struct packed {
        logic       btn_n;
        logic       ren;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl [15];

    function automatic logic [5:0] outs();
        return {level, press, release_pulse, rpt, step, long_hold};
    endfunction

    task automatic check(input string name, input int idx, input logic [5:0] act,
                         input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b (level,press,release,rpt,step,long_hold)",
                     name, idx, act, exp);
        end
    endtask

    task automatic cyc(input logic b, input logic ren);
        btn_n     = b;
        repeat_en = ren;
        @(posedge clk);
        #1;
    endtask

    // Button falls before edge 1, rises before edge 41; rf = edge of first rpt.
    function automatic logic [5:0] exp_hold(input int e, input int rf);
        logic l, p, r, q, g;
        l = (e >= 6) && (e < 46);
        p = (e == 6);
        r = (e == 46);
        q = (e >= rf) && (e < 46) && (((e - rf) % PER) == 0);
        g = (e >= rf) && (e < 46);
        return {l, p, r, q, p | q, g};
    endfunction

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 6'b000000};
        tbl[1]  = '{1'b0, 1'b1, 6'b000000};
        tbl[2]  = '{1'b0, 1'b1, 6'b000000};
        tbl[3]  = '{1'b0, 1'b1, 6'b000000};
        tbl[4]  = '{1'b0, 1'b1, 6'b000000};
        tbl[5]  = '{1'b0, 1'b1, 6'b110010};
        tbl[6]  = '{1'b0, 1'b1, 6'b100000};
        tbl[7]  = '{1'b0, 1'b1, 6'b100000};
        tbl[8]  = '{1'b1, 1'b1, 6'b100000};
        tbl[9]  = '{1'b1, 1'b1, 6'b100000};
        tbl[10] = '{1'b1, 1'b1, 6'b100000};
        tbl[11] = '{1'b1, 1'b1, 6'b100000};
        tbl[12] = '{1'b1, 1'b1, 6'b100000};
        tbl[13] = '{1'b1, 1'b1, 6'b001000};
        tbl[14] = '{1'b1, 1'b1, 6'b000000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, outs(), 6'b000000);
        rst_n = 1'b1;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);

        // Clean press held 8 cycles, then release
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].btn_n, tbl[i].ren);
            check("clean", i + 1, outs(), tbl[i].exp);
        end

        // Long hold with auto-repeat; rpt is due on the release edge (46)
        n_rpt  = 0;
        n_step = 0;
        for (int e = 1; e <= 52; e++) begin
            cyc((e <= 40) ? 1'b0 : 1'b1, 1'b1);
            check("long_rep", e, outs(), exp_hold(e, 16));
            if (rpt)  n_rpt++;
            if (step) n_step++;
            if (e == 46) check("release_vs_rpt", e, {4'b0, release_pulse, rpt}, 6'b000010);
        end
        checks++;
        if (n_rpt != 10 || n_step != 1 + n_rpt) begin
            errors++;
            $display("FAIL step_count: got rpt=%0d step=%0d expected rpt=10 step=11", n_rpt, n_step);
        end

        // Hold with repeat disabled, enabled after press+20
        for (int e = 1; e <= 52; e++) begin
            cyc((e <= 40) ? 1'b0 : 1'b1, (e >= 27) ? 1'b1 : 1'b0);
            check("late_en", e, outs(), exp_hold(e, 27));
        end

        // Bounce: low 2 / high 1, five times, then steady low
        bad     = 1'b0;
        n_press = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0); bad |= level | press;
            cyc(1'b0, 1'b0); bad |= level | press;
            cyc(1'b1, 1'b0); bad |= level | press;
        end
        check("bounce_quiet", 0, {5'b0, bad}, 6'b000000);
        first_press = 0;
        for (int e = 1; e <= 20; e++) begin
            cyc(1'b0, 1'b0);
            if (press) begin
                n_press++;
                if (first_press == 0) first_press = e;
            end
        end
        checks++;
        if (first_press != 6 || n_press != 1) begin
            errors++;
            $display("FAIL bounce_press: got edge=%0d count=%0d expected edge=6 count=1",
                     first_press, n_press);
        end
        for (int e = 1; e <= 12; e++) cyc(1'b1, 1'b0);
        check("bounce_idle", 0, outs(), 6'b000000);

        // Reset asserted mid-REPEAT while the button stays low
        for (int e = 1; e <= 20; e++) cyc(1'b0, 1'b1);
        check("in_repeat", 20, {5'b0, long_hold}, 6'b000001);
        rst_n = 1'b0;
        #1;
        check("async_reset", 0, outs(), 6'b000000);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", 0, outs(), 6'b000000);
        rst_n = 1'b1;
        first_press = 0;
        for (int e = 1; e <= 20; e++) begin
            cyc(1'b0, 1'b1);
            if (press && first_press == 0) first_press = e;
        end
        checks++;
        if (first_press != 6) begin
            errors++;
            $display("FAIL post_reset_press: got edge=%0d expected edge=6", first_press);
        end
        for (int e = 1; e <= 12; e++) cyc(1'b1, 1'b1);
        check("final_idle", 0, outs(), 6'b000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
